// File: rtl/wb_unit.sv
// Writeback stage of the rv32i core: tracks one in-flight rd and drives the register-file write port.
// Optional build macro WB_FWD_EN: forward write-stage results instead of flagging them as hazards.
module wb_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RADDR = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_issue,
    input  logic [RADDR-1:0] i_rd,
    input  logic [1:0]       i_src,
    input  logic [XLEN-1:0]  i_alu_res,
    input  logic [XLEN-1:0]  i_up_reg,
    input  logic [XLEN-1:0]  i_link,
    input  logic             i_ld_valid,
    input  logic [XLEN-1:0]  i_ld_data,
    output logic             o_ld_ready,
    output logic             o_stall,
    input  logic [RADDR-1:0] i_rs1,
    input  logic [RADDR-1:0] i_rs2,
    output logic             o_hazard,
    output logic             o_fwd_rs1,
    output logic             o_fwd_rs2,
    output logic             o_rf_we,
    output logic [RADDR-1:0] o_rf_waddr,
    output logic [XLEN-1:0]  o_rf_wdata
);

    typedef enum logic [1:0] {IDLE, EXEC, LOAD_WAIT} state_e;
    typedef enum logic [1:0] {SRC_ALU, SRC_UPPER, SRC_LOAD, SRC_LINK} src_e;

    state_e           state_q;
    src_e             src_q;
    src_e             src_in;
    logic [RADDR-1:0] rd_q;
    logic             rf_we_q;
    logic [RADDR-1:0] rf_waddr_q;
    logic [XLEN-1:0]  rf_wdata_q;
    logic             ld_ready_q;
    logic             stall_q;
    logic [XLEN-1:0]  exec_res_d;
    logic             pend_hit;
    logic             wb_hit1;
    logic             wb_hit2;

    assign src_in = src_e'(i_src);

    always_comb begin
        exec_res_d = i_alu_res;
        case (src_q)
            SRC_UPPER: exec_res_d = i_up_reg;
            SRC_LINK:  exec_res_d = i_link;
            default:   exec_res_d = i_alu_res;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= SRC_ALU;
            rd_q       <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            ld_ready_q <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            rf_we_q <= 1'b0;
            case (state_q)
                IDLE, EXEC: begin
                    if (state_q == EXEC) begin
                        rf_we_q    <= (rd_q != '0);
                        rf_waddr_q <= rd_q;
                        rf_wdata_q <= exec_res_d;
                    end
                    // EXEC retires and accepts a new issue in the same cycle
                    if (i_issue) begin
                        rd_q  <= i_rd;
                        src_q <= src_in;
                        if (src_in == SRC_LOAD) begin
                            state_q    <= LOAD_WAIT;
                            ld_ready_q <= 1'b1;
                            stall_q    <= 1'b1;
                        end else begin
                            state_q <= EXEC;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                LOAD_WAIT: begin
                    if (i_ld_valid && ld_ready_q) begin
                        rf_we_q    <= (rd_q != '0);
                        rf_waddr_q <= rd_q;
                        rf_wdata_q <= i_ld_data;
                        ld_ready_q <= 1'b0;
                        stall_q    <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pend_hit = (state_q != IDLE) && (rd_q != '0) && ((rd_q == i_rs1) || (rd_q == i_rs2));
    assign wb_hit1  = rf_we_q && (rf_waddr_q != '0) && (rf_waddr_q == i_rs1);
    assign wb_hit2  = rf_we_q && (rf_waddr_q != '0) && (rf_waddr_q == i_rs2);

`ifdef WB_FWD_EN
    assign o_fwd_rs1 = wb_hit1;
    assign o_fwd_rs2 = wb_hit2;
    assign o_hazard  = pend_hit;
`else
    assign o_fwd_rs1 = 1'b0;
    assign o_fwd_rs2 = 1'b0;
    assign o_hazard  = pend_hit || wb_hit1 || wb_hit2;
`endif

    assign o_rf_we    = rf_we_q;
    assign o_rf_waddr = rf_waddr_q;
    assign o_rf_wdata = rf_wdata_q;
    assign o_ld_ready = ld_ready_q;
    assign o_stall    = stall_q;

endmodule

// File: tb/tb_wb_unit.sv
// Directed-vector bench for wb_unit; expectations follow WB_FWD_EN when it is defined.
module tb_wb_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_issue;
    logic [4:0]  i_rd;
    logic [1:0]  i_src;
    logic [31:0] i_alu_res;
    logic [31:0] i_up_reg;
    logic [31:0] i_link;
    logic        i_ld_valid;
    logic [31:0] i_ld_data;
    logic        o_ld_ready;
    logic        o_stall;
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic        o_hazard;
    logic        o_fwd_rs1;
    logic        o_fwd_rs2;
    logic        o_rf_we;
    logic [4:0]  o_rf_waddr;
    logic [31:0] o_rf_wdata;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    wb_unit #(.XLEN(32), .RADDR(5)) dut (
        .clk(clk), .rst(rst),
        .i_issue(i_issue), .i_rd(i_rd), .i_src(i_src),
        .i_alu_res(i_alu_res), .i_up_reg(i_up_reg), .i_link(i_link),
        .i_ld_valid(i_ld_valid), .i_ld_data(i_ld_data), .o_ld_ready(o_ld_ready),
        .o_stall(o_stall), .i_rs1(i_rs1), .i_rs2(i_rs2), .o_hazard(o_hazard),
        .o_fwd_rs1(o_fwd_rs1), .o_fwd_rs2(o_fwd_rs2),
        .o_rf_we(o_rf_we), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [1:0] src);
        i_issue = 1'b1;
        i_rd    = rd;
        i_src   = src;
    endtask

    initial begin
        rst = 1'b1;
        i_issue = 1'b0; i_rd = '0; i_src = '0;
        i_alu_res = '0; i_up_reg = '0; i_link = 32'h0000_1004;
        i_ld_valid = 1'b0; i_ld_data = '0;
        i_rs1 = 5'd1; i_rs2 = 5'd2;
        #2;
        check("rst_we",    32'(o_rf_we),    32'd0);
        check("rst_waddr", 32'(o_rf_waddr), 32'd0);
        check("rst_wdata", o_rf_wdata,      32'd0);
        check("rst_ready", 32'(o_ld_ready), 32'd0);
        check("rst_stall", 32'(o_stall),    32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // ALU write, rd=5
        issue(5'd5, 2'd0); i_alu_res = 32'h0000_1234;
        tick();
        i_issue = 1'b0;
        check("alu_c1_we", 32'(o_rf_we), 32'd0);
        tick();
        check("alu_c2_we",    32'(o_rf_we),    32'd1);
        check("alu_c2_waddr", 32'(o_rf_waddr), 32'd5);
        check("alu_c2_wdata", o_rf_wdata,      32'h0000_1234);
        tick();
        check("alu_c3_we",    32'(o_rf_we), 32'd0);
        check("alu_c3_hold",  o_rf_wdata,   32'h0000_1234);

        // UPPER rd=7 back-to-back with ALU rd=8
        issue(5'd7, 2'd1); i_up_reg = 32'h0001_2000;
        tick();
        issue(5'd8, 2'd0); i_alu_res = 32'h0000_ABCD;
        tick();
        i_issue = 1'b0;
        check("b2b_w1_we",    32'(o_rf_we),    32'd1);
        check("b2b_w1_waddr", 32'(o_rf_waddr), 32'd7);
        check("b2b_w1_wdata", o_rf_wdata,      32'h0001_2000);
        tick();
        check("b2b_w2_we",    32'(o_rf_we),    32'd1);
        check("b2b_w2_waddr", 32'(o_rf_waddr), 32'd8);
        check("b2b_w2_wdata", o_rf_wdata,      32'h0000_ABCD);
        tick();
        check("b2b_done_we", 32'(o_rf_we), 32'd0);

        // LINK source, rd=1
        issue(5'd1, 2'd3); i_link = 32'h0000_2008;
        tick();
        i_issue = 1'b0;
        tick();
        check("link_wdata", o_rf_wdata, 32'h0000_2008);
        tick();

        // LOAD rd=3, data after 4 wait cycles, concurrent issue ignored
        issue(5'd3, 2'd2); i_rs1 = 5'd3;
        tick();
        issue(5'd12, 2'd0); i_alu_res = 32'h0000_5555;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check($sformatf("ld_stall_c%0d", k), 32'(o_stall),    32'd1);
            check($sformatf("ld_ready_c%0d", k), 32'(o_ld_ready), 32'd1);
            check($sformatf("ld_we_c%0d", k),    32'(o_rf_we),    32'd0);
            if (k == 1) check("ld_hazard", 32'(o_hazard), 32'd1);
            if (k == 4) begin
                i_ld_valid = 1'b1; i_ld_data = 32'hDEAD_BEEF;
            end
            tick();
        end
        i_ld_valid = 1'b0; i_issue = 1'b0; i_rs1 = 5'd1;
        check("ld_we",    32'(o_rf_we),    32'd1);
        check("ld_waddr", 32'(o_rf_waddr), 32'd3);
        check("ld_wdata", o_rf_wdata,      32'hDEAD_BEEF);
        check("ld_stall_off", 32'(o_stall),    32'd0);
        check("ld_ready_off", 32'(o_ld_ready), 32'd0);
        tick();
        check("ld_no_issue_we", 32'(o_rf_we), 32'd0);
        tick();
        check("ld_no_issue_we2", 32'(o_rf_we), 32'd0);

        // ld_valid while idle is ignored
        i_ld_valid = 1'b1; i_ld_data = 32'h1111_1111;
        tick();
        i_ld_valid = 1'b0;
        tick();
        check("idle_ldv_we", 32'(o_rf_we), 32'd0);

        // rd=0 never writes or hazards
        issue(5'd0, 2'd0); i_rs1 = 5'd0; i_alu_res = 32'h0000_7777;
        #1;
        check("rd0_idle_hz", 32'(o_hazard), 32'd0);
        tick();
        i_issue = 1'b0;
        check("rd0_exec_hz", 32'(o_hazard), 32'd0);
        tick();
        check("rd0_we", 32'(o_rf_we),  32'd0);
        check("rd0_hz", 32'(o_hazard), 32'd0);
        tick();

        // hazard / forwarding on rd=9 via rs2
        i_rs1 = 5'd1; i_rs2 = 5'd9;
        issue(5'd9, 2'd0); i_alu_res = 32'h0000_0099;
        tick();
        i_issue = 1'b0;
        check("hz_exec", 32'(o_hazard), 32'd1);
        tick();
        check("hz_wb_we", 32'(o_rf_we), 32'd1);
`ifdef WB_FWD_EN
        check("hz_wb_hazard", 32'(o_hazard),  32'd0);
        check("hz_wb_fwd2",   32'(o_fwd_rs2), 32'd1);
`else
        check("hz_wb_hazard", 32'(o_hazard),  32'd1);
        check("hz_wb_fwd2",   32'(o_fwd_rs2), 32'd0);
`endif
        check("hz_wb_fwd1", 32'(o_fwd_rs1), 32'd0);
        tick();
        check("hz_after", 32'(o_hazard), 32'd0);
        i_rs2 = 5'd2;

        // async reset in LOAD_WAIT discards the load
        issue(5'd4, 2'd2);
        tick();
        i_issue = 1'b0;
        check("rl_stall", 32'(o_stall), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rl_ready", 32'(o_ld_ready), 32'd0);
        check("rl_stall0", 32'(o_stall),   32'd0);
        check("rl_we",    32'(o_rf_we),    32'd0);
        tick();
        rst = 1'b0;
        i_ld_valid = 1'b1; i_ld_data = 32'h2222_2222;
        tick();
        i_ld_valid = 1'b0;
        tick();
        check("rl_no_write", 32'(o_rf_we), 32'd0);
        check("rl_wdata",    o_rf_wdata,   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
